sd_dat_rx: RTL and testbench
============================

Name: sd_dat_rx

Overview:
- Host-side 4-bit SD DAT line receiver for single- and multi-block reads.
- Detects the start bit, deserializes nibbles into 32-bit words and checks a CRC16 on each DAT line.
- Also checks the end bit, counts blocks and applies a start-bit timeout.
- Sits between the DAT pads (card clock domain) and the host read buffer/DMA; armed by the transfer control logic after the read command is issued.

Parameters:
TIMEOUT, 1024, max CLK cycles spent waiting for a start bit (first block and between blocks)
MAX_BLK_SIZE, 2048, largest accepted block size in bytes

Ports:
CLK  input  1  SD card clock; everything sampled on rising edge
RESET  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: arm a transfer using blk_size/blk_cnt
abort  input  1  return to IDLE next cycle; no done pulse
blk_size  input  12  block size in bytes
blk_cnt  input  16  number of blocks
data_in  input  4  DAT[3:0] from card; idle high
word_out  output  32  received word; first byte of the word in [7:0]
word_valid  output  1  word_out holds a new word
word_ready  input  1  buffer accepts word_out this cycle
busy  output  1  high outside IDLE
blocks_done  output  16  blocks fully received and good in current transfer
done  output  1  one-cycle pulse after the last good end bit
crc_err, end_err, timeout_err, overrun_err, cfg_err  output  1 each  sticky error flags; cleared by start

Behaviour:
- Reset (RESET=0, asynchronous):
  - state IDLE; all outputs 0; word_out=0.
- start accepted only in IDLE:
  - start in any other state is ignored.
  - All error flags and blocks_done are cleared on accept.
- Config check at start:
  - Error if blk_size==0, blk_size[1:0]!=0, blk_size>MAX_BLK_SIZE or blk_cnt==0.
  - On error: set cfg_err, stay IDLE, busy stays 0.
- States: IDLE -> WAIT_START -> DATA -> CRC -> END -> (WAIT_START | IDLE).
- WAIT_START:
  - Timeout counter resets on entry.
  - data_in==4'h0 -> DATA; the nibble counter clears.
  - Partial low (some lines 0, not all) -> end_err, IDLE.
  - Counter reaching TIMEOUT -> timeout_err, IDLE.
- DATA:
  - Receives 2*blk_size nibbles, one per cycle, MSB-first.
  - Even nibble = byte[7:4], odd nibble = byte[3:0].
  - Bytes are packed little-endian into the word (byte 0 -> [7:0]).
  - Each line d feeds its own CRC16 (poly x^16+x^12+x^5+1, init 0) with bit data_in[d].
- Word handoff:
  - word_valid asserts the cycle after the 8th nibble of a word is sampled.
  - word_valid drops on the cycle after word_valid&&word_ready.
  - If a new word completes while word_valid is still high, set overrun_err and go to IDLE. The pending word is kept until accepted.
- CRC:
  - 16 nibbles are compared bitwise, MSB-first, against each line's CRC register.
  - Any mismatch sets crc_err; comparison continues through END, then IDLE.
- END:
  - data_in must be 4'hF; otherwise end_err, IDLE.
  - If good and crc_err=0: blocks_done increments.
  - Then, if blocks_done(new)==blk_cnt: done pulse, IDLE. Otherwise WAIT_START.
- Errors and abort:
  - Errors never produce done.
  - abort has priority over every other event in the same cycle.
  - abort clears word_valid but not the error flags.
- Counters:
  - nibble counter 13 bits; CRC counter 4 bits; timeout counter clog2(TIMEOUT+1) bits.
  - blocks_done has no wrap (blk_cnt<=65535).

Test Plan:
- Single block, blk_size=4, blk_cnt=1, start bit then nibbles 1,2,3,4,5,6,7,8 with correct CRCs and end 4'hF -> one word 0x78563412, blocks_done=1, done pulse, no errors.
- blk_size=64, blk_cnt=10, every payload nibble 0, CRC nibbles all 0 (CRC of zeros), word_ready=1 -> 160 words of 0x00000000, blocks_done=10, done once.
- Same as the first scenario but one CRC nibble on DAT2 flipped -> crc_err=1, blocks_done=0, no done, busy=0 after END.
- TIMEOUT=16, data_in held 4'hF after start -> timeout_err at the 16th cycle, IDLE, no word_valid.
- blk_size=64, word_ready=0 throughout -> first word held stable; overrun_err when the second word completes (16 nibbles after the start bit).
- start with blk_size=6 -> cfg_err=1, busy stays 0. Abort issued mid-DATA of a valid transfer -> IDLE next cycle, word_valid=0, no done.

Source files
------------

// File: rtl/sd_dat_rx.sv
// Host-side 4-bit SD DAT receiver: start-bit detect, nibble deserialisation into
// 32-bit words, per-line CRC16 check, end-bit check, block counting and start timeout.
//
// state        | meaning
// S_IDLE       | not armed; waits for start with a legal configuration
// S_WAIT_START | waiting for all four lines low, bounded by the timeout counter
// S_DATA       | receiving 2*blk_size payload nibbles
// S_CRC        | comparing 16 CRC nibbles against each line's CRC register
// S_END        | checking the end bit and closing out the block
module sd_dat_rx #(
   parameter int TIMEOUT      = 1024,
   parameter int MAX_BLK_SIZE = 2048
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        start,
   input  logic        abort,
   input  logic [11:0] blk_size,
   input  logic [15:0] blk_cnt,
   input  logic [3:0]  data_in,
   output logic [31:0] word_out,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        busy,
   output logic [15:0] blocks_done,
   output logic        done,
   output logic        crc_err,
   output logic        end_err,
   output logic        timeout_err,
   output logic        overrun_err,
   output logic        cfg_err
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END} state_t;

   state_t        state;
   logic [TW-1:0] tmo_cnt;
   logic [12:0]   nib_cnt;
   logic [3:0]    crc_cnt;
   logic [11:0]   blk_size_q;
   logic [15:0]   blk_cnt_q;
   logic [31:0]   word_sr;
   logic [15:0]   crc     [4];
   logic [15:0]   crc_nxt [4];
   logic [3:0]    crc_miss;
   logic [31:0]   word_nxt;
   logic [4:0]    nib_pos;
   logic [12:0]   nib_last;
   logic [15:0]   blocks_inc;
   logic          cfg_bad;

   assign busy       = (state != S_IDLE);
   assign nib_last   = {blk_size_q, 1'b0} - 13'd1;
   assign blocks_inc = blocks_done + 16'd1;
   assign cfg_bad    = (blk_size == 12'd0) || (blk_size[1:0] != 2'b00) ||
                       (32'(blk_size) > MAX_BLK_SIZE) || (blk_cnt == 16'd0);

   // Even nibble of a byte is the high half; bytes land little-endian in the word.
   assign nib_pos = {nib_cnt[2:1], ~nib_cnt[0], 2'b00};

   always_comb begin
      word_nxt = word_sr;
      word_nxt[nib_pos +: 4] = data_in;
      for (int d = 0; d < 4; d++) begin
         crc_miss[d] = crc[d][15] ^ data_in[d];
         crc_nxt[d]  = {crc[d][14:0], 1'b0} ^ (crc_miss[d] ? 16'h1021 : 16'h0000);
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= S_IDLE;
         tmo_cnt     <= '0;
         nib_cnt     <= '0;
         crc_cnt     <= '0;
         blk_size_q  <= '0;
         blk_cnt_q   <= '0;
         word_sr     <= '0;
         word_out    <= '0;
         word_valid  <= 1'b0;
         blocks_done <= '0;
         done        <= 1'b0;
         crc_err     <= 1'b0;
         end_err     <= 1'b0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
         cfg_err     <= 1'b0;
         for (int d = 0; d < 4; d++) crc[d] <= '0;
      end else begin
         done <= 1'b0;
         if (word_valid && word_ready) word_valid <= 1'b0;
         if (abort) begin
            state      <= S_IDLE;
            word_valid <= 1'b0;
         end else begin
            case (state)
               S_IDLE: if (start) begin
                  blocks_done <= '0;
                  crc_err     <= 1'b0;
                  end_err     <= 1'b0;
                  timeout_err <= 1'b0;
                  overrun_err <= 1'b0;
                  cfg_err     <= cfg_bad;
                  if (!cfg_bad) begin
                     blk_size_q <= blk_size;
                     blk_cnt_q  <= blk_cnt;
                     tmo_cnt    <= TMO_LOAD;
                     state      <= S_WAIT_START;
                  end
               end
               S_WAIT_START: begin
                  if (data_in == 4'h0) begin
                     nib_cnt <= '0;
                     for (int d = 0; d < 4; d++) crc[d] <= '0;
                     state   <= S_DATA;
                  end else if (data_in != 4'hF) begin
                     end_err <= 1'b1;
                     state   <= S_IDLE;
                  end else if (tmo_cnt == '0) begin
                     timeout_err <= 1'b1;
                     state       <= S_IDLE;
                  end else begin
                     tmo_cnt <= tmo_cnt - 1'b1;
                  end
               end
               S_DATA: begin
                  for (int d = 0; d < 4; d++) crc[d] <= crc_nxt[d];
                  word_sr <= word_nxt;
                  nib_cnt <= nib_cnt + 13'd1;
                  if (nib_cnt[2:0] == 3'd7 && word_valid && !word_ready) begin
                     // Pending word is left in place; only the new one is lost.
                     overrun_err <= 1'b1;
                     state       <= S_IDLE;
                  end else begin
                     if (nib_cnt[2:0] == 3'd7) begin
                        word_out   <= word_nxt;
                        word_valid <= 1'b1;
                     end
                     if (nib_cnt == nib_last) begin
                        crc_cnt <= 4'd15;
                        state   <= S_CRC;
                     end
                  end
               end
               S_CRC: begin
                  if (crc_miss != 4'b0000) crc_err <= 1'b1;
                  for (int d = 0; d < 4; d++) crc[d] <= {crc[d][14:0], 1'b0};
                  if (crc_cnt == 4'd0) state <= S_END;
                  else                 crc_cnt <= crc_cnt - 4'd1;
               end
               S_END: begin
                  if (data_in != 4'hF) begin
                     end_err <= 1'b1;
                     state   <= S_IDLE;
                  end else if (crc_err) begin
                     state <= S_IDLE;
                  end else begin
                     blocks_done <= blocks_inc;
                     if (blocks_inc == blk_cnt_q) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                     end else begin
                        tmo_cnt <= TMO_LOAD;
                        state   <= S_WAIT_START;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_dat_rx.sv
// Directed bench for sd_dat_rx: single/multi-block reads, CRC and end-bit errors,
// timeout, overrun, config rejection and abort.
module tb_sd_dat_rx;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        start, abort;
   logic [11:0] blk_size;
   logic [15:0] blk_cnt;
   logic [3:0]  data_in;
   logic [31:0] word_out;
   logic        word_valid, word_ready, busy, done;
   logic [15:0] blocks_done;
   logic        crc_err, end_err, timeout_err, overrun_err, cfg_err;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] rx_words [$];
   int          done_cnt = 0;
   logic [3:0]  pay [$];

   sd_dat_rx #(.TIMEOUT(16), .MAX_BLK_SIZE(2048)) dut (
      .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
      .blk_size(blk_size), .blk_cnt(blk_cnt), .data_in(data_in),
      .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
      .busy(busy), .blocks_done(blocks_done), .done(done),
      .crc_err(crc_err), .end_err(end_err), .timeout_err(timeout_err),
      .overrun_err(overrun_err), .cfg_err(cfg_err)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (word_valid && word_ready) rx_words.push_back(word_out);
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   task automatic drive(input logic [3:0] n);
      data_in = n;
      @(posedge CLK); #1;
   endtask

   task automatic do_start(input logic [11:0] sz, input logic [15:0] cnt);
      blk_size = sz;
      blk_cnt  = cnt;
      start    = 1'b1;
      @(posedge CLK); #1;
      start    = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      @(posedge CLK); #1;
      abort = 1'b0;
   endtask

   // Start bit, payload from pay[], per-line CRC (optionally one bit flipped), end bit.
   task automatic send_block(input int flip_line, input int flip_idx);
      logic [15:0] c [4];
      logic [3:0]  n;
      for (int d = 0; d < 4; d++) c[d] = 16'h0000;
      drive(4'h0);
      for (int i = 0; i < pay.size(); i++) begin
         for (int d = 0; d < 4; d++) c[d] = crc_step(c[d], pay[i][d]);
         drive(pay[i]);
      end
      for (int k = 0; k < 16; k++) begin
         for (int d = 0; d < 4; d++) begin
            n[d] = c[d][15-k];
            if (d == flip_line && k == flip_idx) n[d] = ~n[d];
         end
         drive(n);
      end
      drive(4'hF);
   endtask

   function automatic logic [4:0] errs();
      return {crc_err, end_err, timeout_err, overrun_err, cfg_err};
   endfunction

   initial begin
      int base_w, base_d;
      logic [31:0] acc;
      RESET = 1'b0; start = 1'b0; abort = 1'b0; blk_size = '0; blk_cnt = '0;
      data_in = 4'hF; word_ready = 1'b1;
      #22;
      check("rst_word_out", word_out, 32'h0);
      check("rst_valid", {31'b0, word_valid}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_blocks", {16'b0, blocks_done}, 32'h0);
      check("rst_errs", {27'b0, errs()}, 32'h0);
      RESET = 1'b1;
      @(posedge CLK); #1;

      // Configuration rejection
      do_start(12'd6, 16'd1);
      check("cfg_size6_err", {31'b0, cfg_err}, 32'h1);
      check("cfg_size6_busy", {31'b0, busy}, 32'h0);
      do_start(12'd0, 16'd1);
      check("cfg_size0_err", {31'b0, cfg_err}, 32'h1);
      do_start(12'd2052, 16'd1);
      check("cfg_big_err", {31'b0, cfg_err}, 32'h1);
      do_start(12'd8, 16'd0);
      check("cfg_cnt0_err", {31'b0, cfg_err}, 32'h1);
      do_start(12'd2048, 16'd1);
      check("cfg_max_ok", {31'b0, cfg_err}, 32'h0);
      check("cfg_max_busy", {31'b0, busy}, 32'h1);
      do_abort();
      check("abort_idle_busy", {31'b0, busy}, 32'h0);

      // Single good block, nibbles 1..8
      pay = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
      base_w = rx_words.size(); base_d = done_cnt;
      do_start(12'd4, 16'd1);
      send_block(-1, -1);
      check("t1_done", {31'b0, done}, 32'h1);
      check("t1_busy", {31'b0, busy}, 32'h0);
      check("t1_blocks", {16'b0, blocks_done}, 32'd1);
      check("t1_errs", {27'b0, errs()}, 32'h0);
      check("t1_nwords", rx_words.size() - base_w, 32'd1);
      if (rx_words.size() > base_w) check("t1_word", rx_words[base_w], 32'h78563412);
      @(posedge CLK); #1;
      check("t1_done_cnt", done_cnt - base_d, 32'd1);

      // Ten 64-byte blocks of zeros
      pay.delete();
      for (int i = 0; i < 128; i++) pay.push_back(4'h0);
      base_w = rx_words.size(); base_d = done_cnt;
      do_start(12'd64, 16'd10);
      for (int b = 0; b < 10; b++) send_block(-1, -1);
      @(posedge CLK); #1;
      check("t2_nwords", rx_words.size() - base_w, 32'd160);
      acc = '0;
      for (int i = base_w; i < rx_words.size(); i++) acc = acc | rx_words[i];
      check("t2_words_zero", acc, 32'h0);
      check("t2_blocks", {16'b0, blocks_done}, 32'd10);
      check("t2_done_cnt", done_cnt - base_d, 32'd1);
      check("t2_errs", {27'b0, errs()}, 32'h0);

      // CRC nibble flipped on DAT2
      pay = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
      base_d = done_cnt;
      do_start(12'd4, 16'd1);
      send_block(2, 5);
      check("t3_crc_err", {31'b0, crc_err}, 32'h1);
      check("t3_blocks", {16'b0, blocks_done}, 32'd0);
      check("t3_busy", {31'b0, busy}, 32'h0);
      @(posedge CLK); #1;
      check("t3_no_done", done_cnt - base_d, 32'd0);

      // Start-bit timeout with lines idle
      data_in = 4'hF;
      do_start(12'd4, 16'd1);
      repeat (15) @(posedge CLK);
      #1;
      check("t4_busy_15", {31'b0, busy}, 32'h1);
      check("t4_tmo_15", {31'b0, timeout_err}, 32'h0);
      @(posedge CLK); #1;
      check("t4_tmo_16", {31'b0, timeout_err}, 32'h1);
      check("t4_busy_16", {31'b0, busy}, 32'h0);
      check("t4_valid", {31'b0, word_valid}, 32'h0);

      // Partial-low start bit
      do_start(12'd4, 16'd1);
      drive(4'hB);
      check("t5_end_err", {31'b0, end_err}, 32'h1);
      check("t5_busy", {31'b0, busy}, 32'h0);
      data_in = 4'hF;

      // Overrun with word_ready held low
      word_ready = 1'b0;
      do_start(12'd64, 16'd1);
      drive(4'h0);
      for (int i = 1; i <= 8; i++) drive(4'(i));
      check("t6_valid1", {31'b0, word_valid}, 32'h1);
      check("t6_word1", word_out, 32'h78563412);
      for (int i = 9; i <= 15; i++) drive(4'(i));
      check("t6_no_ovr_yet", {31'b0, overrun_err}, 32'h0);
      drive(4'h0);
      check("t6_overrun", {31'b0, overrun_err}, 32'h1);
      check("t6_busy", {31'b0, busy}, 32'h0);
      check("t6_word_kept", word_out, 32'h78563412);
      check("t6_valid_kept", {31'b0, word_valid}, 32'h1);
      data_in = 4'hF;
      word_ready = 1'b1;
      @(posedge CLK); #1;
      check("t6_valid_drop", {31'b0, word_valid}, 32'h0);

      // Abort mid-DATA with a pending word
      word_ready = 1'b0;
      base_d = done_cnt;
      do_start(12'd64, 16'd1);
      check("t7_ovr_cleared", {31'b0, overrun_err}, 32'h0);
      drive(4'h0);
      for (int i = 0; i < 9; i++) drive(4'hA);
      check("t7_valid_pre", {31'b0, word_valid}, 32'h1);
      do_abort();
      check("t7_busy", {31'b0, busy}, 32'h0);
      check("t7_valid", {31'b0, word_valid}, 32'h0);
      data_in = 4'hF;
      word_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("t7_no_done", done_cnt - base_d, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
